pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline-stage register for the CPU datapath. It replaces hand-written inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries a data bundle and a control bundle under a valid/ready handshake. It supports back-pressure and flush, and turns flushed or empty slots into zero-control bubbles. An optional skid entry lets the block run at full throughput with a registered `in_ready`.

---
 rtl/pipe_stage_reg.sv | 177 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: data + control bundles under valid/ready, with flush.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [1:0]        r_count;
  logic              w_acc;
  logic              w_deq;
  logic              w_in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;

  // Ready comes straight from a flop, so out_ready never reaches in_ready.
  assign w_in_ready = r_in_ready;
`else
  assign w_in_ready = !r_out_valid || out_ready;
`endif

  assign w_acc = in_valid && w_in_ready;
  assign w_deq = r_out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      // Held entries and the offered input are all dropped; out_data keeps its value.
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_count     <= 2'd1;
          end
          r_in_ready <= 1'b1;
        end
        ST_FULL: begin
          if (w_acc && w_deq) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_in_ready  <= 1'b1;
          end else if (w_acc) begin
            r_state     <= ST_SKID;
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_count     <= 2'd2;
            r_in_ready  <= 1'b0;
          end else if (w_deq) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_main_ctrl <= '0;
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_SKID: begin
          if (w_deq) begin
            r_state     <= ST_FULL;
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_skid_ctrl <= '0;
            r_count     <= 2'd1;
            r_in_ready  <= 1'b1;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_main_ctrl <= '0;
          r_count     <= 2'd0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_count     <= 2'd0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_main_ctrl <= '0;
      r_count     <= 2'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_count     <= 2'd1;
          end
        end
        ST_FULL: begin
          // Accepting while full implies out_ready, so the head is replaced in place.
          if (w_acc) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_deq) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_main_ctrl <= '0;
            r_count     <= 2'd0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_main_ctrl <= '0;
          r_count     <= 2'd0;
        end
      endcase
    end
  end
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (either build of PIPE_STAGE_SKID_EN).
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic        flush;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    tick();

    // Back-to-back streaming 1..8 with downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i; in_ctrl = 8'h0F;
      #1;
      chk($sformatf("stream_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream_data_%0d", i), out_data, i);
      chk($sformatf("stream_ctrl_%0d", i), {24'd0, out_ctrl}, 32'h0F);
      chk($sformatf("stream_count_%0d", i), {30'd0, count}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("drain_count", {30'd0, count}, 32'd0);
    chk("drain_data_hold", out_data, 32'd8);

    // Back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h03;
    tick();
    chk("bp_head", out_data, 32'h11);
    chk("bp_count1", {30'd0, count}, 32'd1);
    in_data = 32'h22; in_ctrl = 8'h05;
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_count2", {30'd0, count}, 32'd2);
    chk("bp_in_ready_skid", {31'd0, in_ready}, 32'd0);
    chk("bp_head_stable", out_data, 32'h11);
    tick();
    chk("bp_head_stable2", out_data, 32'h11);
    chk("bp_ctrl_stable", {24'd0, out_ctrl}, 32'h03);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_noncomb", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_second", out_data, 32'h22);
    chk("bp_second_ctrl", {24'd0, out_ctrl}, 32'h05);
    chk("bp_in_ready_after_deq", {31'd0, in_ready}, 32'd1);
    chk("bp_count_after_deq", {30'd0, count}, 32'd1);
    // Simultaneous accept and dequeue while FULL
    in_valid = 1'b1; in_data = 32'h2A; in_ctrl = 8'h07;
    tick();
    chk("sim_data", out_data, 32'h2A);
    chk("sim_count", {30'd0, count}, 32'd1);
    in_valid = 1'b0;
    tick();
`else
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_head_stable", out_data, 32'h11);
    chk("bp_ctrl_stable", {24'd0, out_ctrl}, 32'h03);
    chk("bp_count_max1", {30'd0, count}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", {31'd0, in_ready}, 32'd1);
    tick();
    chk("sim_data", out_data, 32'h22);
    chk("sim_ctrl", {24'd0, out_ctrl}, 32'h05);
    chk("sim_count", {30'd0, count}, 32'd1);
    in_valid = 1'b0;
    tick();
`endif
    chk("empty_before_flush", {31'd0, out_valid}, 32'd0);

    // Flush with entries held and an input offered in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h03;
    tick();
    in_data = 32'h22; in_ctrl = 8'h05;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    chk("fl_pre_count", {30'd0, count}, 32'd2);
`else
    chk("fl_pre_count", {30'd0, count}, 32'd1);
`endif
    in_data = 32'h33; in_ctrl = 8'h09; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("fl_count", {30'd0, count}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_data_stable", out_data, 32'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fl_no_resurrect_%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset asserted mid-cycle while holding an entry
    in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("arst_count", {30'd0, count}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h66; in_ctrl = 8'h0C;
    tick();
    in_valid = 1'b0;
    chk("post_rst_data", out_data, 32'h66);
    chk("post_rst_ctrl", {24'd0, out_ctrl}, 32'h0C);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("post_rst_drain", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
